// File: rtl/rpn_pkg.sv
// Shared constants for the RPN stack engine: one-hot opcodes, status bit
// positions and the sequencing FSM state type.
package rpn_pkg;

  localparam int OP_CLEAR = 0;
  localparam int OP_PUSH  = 1;
  localparam int OP_POP   = 2;
  localparam int OP_ADD   = 3;
  localparam int OP_SUB   = 4;
  localparam int OP_MUL   = 5;
  localparam int OP_DUP   = 6;
  localparam int OP_SWAP  = 7;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_PUSH  = 8'h02;
  localparam logic [7:0] CMD_POP   = 8'h04;
  localparam logic [7:0] CMD_ADD   = 8'h08;
  localparam logic [7:0] CMD_SUB   = 8'h10;
  localparam logic [7:0] CMD_MUL   = 8'h20;
  localparam logic [7:0] CMD_DUP   = 8'h40;
  localparam logic [7:0] CMD_SWAP  = 8'h80;

  localparam int STAT_OVERFLOW  = 0;
  localparam int STAT_UNDERFLOW = 1;
  localparam int STAT_ILLEGAL   = 2;
  localparam int STAT_WRAP      = 3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } rpn_state_e;

endpackage

// File: rtl/rpn_seq_multiplier.sv
// Radix-2 shift-add multiplier: first partial product folded in on the start
// edge, the rest one bit per cycle; done pulses once the full product is valid.
module rpn_seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CW = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;
  logic                running;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Bit 0 is consumed here so the product lands after DATA_W-1 more edges.
        product <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
        mcand   <= {{(DATA_W-1){1'b0}}, a, 1'b0};
        mplier  <= b >> 1;
        cnt     <= CW'(1);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(DATA_W-1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack-machine core: one-hot commands on a DEPTH-entry register stack,
// single-cycle push/pop/add/sub/dup/swap plus a DATA_W-cycle sequential multiply.
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_areset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          top0,
  output logic [DATA_W-1:0]          top1,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic [3:0]                 status,
  output logic                       busy
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  rpn_state_e state_q, state_d;

  logic [DATA_W-1:0]   entries [DEPTH];
  logic [IW-1:0]       p0, p1, pw;
  logic                has1, has2, full;
  logic                cmd_fire;
  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic [DATA_W:0]     sum, diff;

  assign p0   = IW'(depth - DW'(1));
  assign p1   = IW'(depth - DW'(2));
  assign pw   = IW'(depth);
  assign has1 = (depth != '0);
  assign has2 = (depth >= DW'(2));
  assign full = (depth == DW'(DEPTH));

  assign top0 = has1 ? entries[p0] : '0;
  assign top1 = has2 ? entries[p1] : '0;

  // Carry/borrow fall out as the extra top bit.
  assign sum  = {1'b0, top1} + {1'b0, top0};
  assign diff = {1'b0, top1} - {1'b0, top0};

  assign cmd_fire = cmd_valid && (state_q == ST_IDLE);

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd == CMD_MUL) && has2) begin
          mul_start = 1'b1;
          state_d   = ST_MUL_RUN;
        end
      end
      ST_MUL_RUN: begin
        busy = 1'b1;
        if (mul_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  rpn_seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .s00_axi_aclk   (s00_axi_aclk),
    .s00_axi_areset (s00_axi_areset),
    .start          (mul_start),
    .a              (top1),
    .b              (top0),
    .done           (mul_done),
    .product        (mul_product)
  );

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      depth  <= '0;
      status <= '0;
    end else if (state_q == ST_MUL_RUN) begin
      if (mul_done) begin
        entries[p1] <= mul_product[DATA_W-1:0];
        depth       <= depth - DW'(1);
        if (|mul_product[2*DATA_W-1:DATA_W]) status[STAT_WRAP] <= 1'b1;
      end
    end else if (cmd_fire) begin
      case (cmd)
        CMD_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
          depth  <= '0;
          status <= '0;
        end
        CMD_PUSH: begin
          if (full) status[STAT_OVERFLOW] <= 1'b1;
          else begin
            entries[pw] <= push_data;
            depth       <= depth + DW'(1);
          end
        end
        CMD_POP: begin
          if (!has1) status[STAT_UNDERFLOW] <= 1'b1;
          else       depth <= depth - DW'(1);
        end
        CMD_ADD: begin
          if (!has2) status[STAT_UNDERFLOW] <= 1'b1;
          else begin
            entries[p1] <= sum[DATA_W-1:0];
            depth       <= depth - DW'(1);
            if (sum[DATA_W]) status[STAT_WRAP] <= 1'b1;
          end
        end
        CMD_SUB: begin
          if (!has2) status[STAT_UNDERFLOW] <= 1'b1;
          else begin
            entries[p1] <= diff[DATA_W-1:0];
            depth       <= depth - DW'(1);
            if (diff[DATA_W]) status[STAT_WRAP] <= 1'b1;
          end
        end
        // A legal MUL is carried by the FSM; only the short-stack error lands here.
        CMD_MUL: begin
          if (!has2) status[STAT_UNDERFLOW] <= 1'b1;
        end
        CMD_DUP: begin
          if (!has1)     status[STAT_UNDERFLOW] <= 1'b1;
          else if (full) status[STAT_OVERFLOW]  <= 1'b1;
          else begin
            entries[pw] <= top0;
            depth       <= depth + DW'(1);
          end
        end
        CMD_SWAP: begin
          if (!has2) status[STAT_UNDERFLOW] <= 1'b1;
          else begin
            entries[p0] <= top1;
            entries[p1] <= top0;
          end
        end
        default: status[STAT_ILLEGAL] <= 1'b1;
      endcase
    end
  end

endmodule
